md_scheduler: RTL and testbench
===============================

# md_scheduler

Multiply/divide sequencing unit for the five-stage pipeline. It sits in the EX stage beside the ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations, owns the HI and LO registers, and holds `busy` for a fixed per-operation latency. It also produces the D-stage stall request for any instruction that touches HI/LO while an operation is in flight. Its `md_out` is the HI/LO read value that the writeback selector forwards as `mdOut`.

## Interface
- `MULT_LAT`, default 5: busy cycles for MULT/MULTU (legal range 1–15).
- `DIV_LAT`, default 10: busy cycles for DIV/DIVU (legal range 1–15).

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Reset is synchronous and active-low: when `reset` is 0 at a rising edge, all state is reset.
- `start`  in  1  EX-stage pulse; sample `md_op` this cycle.
- `md_op`  in  3  Operation code: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as none.
- `rs_data`  in  32  Forwarded rs operand (dividend/multiplicand, or MTHI/MTLO source).
- `rt_data`  in  32  Forwarded rt operand (divisor/multiplier).
- `rd_sel`  in  1  Read select: 0 HI, 1 LO.
- `md_use_D`  in  1  Instruction in D stage is mult/div/mfhi/mflo/mthi/mtlo.
- `busy`  out  1  Operation in flight.
- `md_stall`  out  1  Stall request to the hazard unit.
- `md_out`  out  32  Selected HI or LO (combinational from the registers).

## Operation
- States: IDLE, MUL, DIV. The state register, a 4-bit countdown `cnt`, the pending HI/LO result registers, HI and LO all reset to 0 / IDLE.
- IDLE + `start` + op 1/2:
  - Compute the 64-bit product: signed for op 1, unsigned for op 2.
  - Latch {hi,lo} = product into the pending registers.
  - `cnt` ← `MULT_LAT`−1; go to MUL.
- IDLE + `start` + op 3/4:
  - Pending LO ← quotient, pending HI ← remainder.
  - Op 3 is signed: quotient truncates toward zero and the remainder takes the sign of the dividend.
  - Op 4 is unsigned.
  - `cnt` ← `DIV_LAT`−1; go to DIV.
  - If `rt_data`==0, still go busy for `DIV_LAT` cycles, but HI/LO are left unchanged at completion. Keep a div-by-zero flag internally.
- IDLE + `start` + op 5: HI ← `rs_data` at this edge; no busy.
- IDLE + `start` + op 6: LO ← `rs_data` at this edge; no busy.
- MUL/DIV:
  - `cnt` decrements each cycle.
  - At the edge where `cnt`==0, commit pending to HI/LO (unless div-by-zero) and return to IDLE.
- `start` while in MUL/DIV is ignored entirely. The hazard unit guarantees this does not happen; the ignore is a safety requirement.
- Op 0/7 with `start`: no effect.
- `busy` = (state != IDLE).
- `md_stall` = `md_use_D` & (`busy` | (`start` & op∈{1,2,3,4})). This is combinational.
- `md_out` = `rd_sel` ? LO : HI. It reflects committed values only, never pending ones.
- Reset mid-operation: abort, state IDLE, HI = LO = 0, `busy` 0 on the following cycle; the pending result is discarded.

## Timing
- Reset values: `busy`=0, `md_out`=0, `md_stall`=`md_use_D` & `start` & op∈{1..4}.
- `start` sampled at edge E0:
  - `busy` is high for exactly LAT cycles, from the cycle after E0 through cycle E0+LAT.
  - HI/LO change at edge E0+LAT.
  - `busy` is low and `md_out` shows the new value starting the cycle after edge E0+LAT.
- Back-to-back: a new `start` is accepted in the first cycle `busy` is low.
- MTHI/MTLO: one-cycle latency; `md_out` updates the cycle after the edge.
- `md_stall` asserts in the same cycle as `start` (before `busy` rises), so a following mfhi in D is held.

## Test plan
- MULT −3 × 5 (rs=0xFFFFFFFD, rt=5), `MULT_LAT`=5 → `busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 2 → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles. DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles. DIVU 7/2 → LO=3, HI=1.
- DIV by 0 with HI=0x11, LO=0x22 preset via MTHI/MTLO → `busy` 10 cycles, then HI=0x11, LO=0x22 unchanged.
- Hold `md_use_D`=1 with MULT start → `md_stall`=1 from the start cycle through the last busy cycle, 0 after. A second `start` (DIV) issued mid-MUL → ignored; result matches the MULT only.
- Reset (`reset`=0) during DIV at busy cycle 4 → next cycle `busy`=0, HI=LO=0, and no late commit.
- MTHI 0xDEADBEEF then `rd_sel`=0 → `md_out`=0xDEADBEEF the next cycle. MTLO 0x1234 with `rd_sel`=1 → `md_out`=0x1234.

Source files
------------

// File: rtl/md_scheduler.sv
// md_scheduler: EX-stage multiply/divide sequencer owning HI/LO.
// Ports: clk, reset (sync, active-low), start/md_op/rs_data/rt_data
//   in; rd_sel selects HI(0)/LO(1); md_use_D flags a D-stage HI/LO user;
//   busy, md_stall, md_out out.
module md_scheduler #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        rd_sel,
    input  logic        md_use_D,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] md_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] phi_q, phi_d;
    logic [31:0] plo_q, plo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dz_q, dz_d;

    logic        op_mul;
    logic        op_div;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    logic        dsgn;
    logic [31:0] mag_a, mag_b;
    logic [31:0] q_u, r_u;
    logic [31:0] quo, rem;

    assign op_mul = (md_op == 3'd1) || (md_op == 3'd2);
    assign op_div = (md_op == 3'd3) || (md_op == 3'd4);

    assign prod_s = $signed({{32{rs_data[31]}}, rs_data})
                  * $signed({{32{rt_data[31]}}, rt_data});
    assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

    // Signed divide runs on magnitudes so the most-negative / -1 case
    // wraps predictably instead of relying on signed-divide overflow.
    assign dsgn  = (md_op == 3'd3);
    assign mag_a = (dsgn && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
    assign mag_b = (dsgn && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;
    assign q_u   = (mag_b == 32'd0) ? 32'd0 : (mag_a / mag_b);
    assign r_u   = (mag_b == 32'd0) ? 32'd0 : (mag_a % mag_b);
    assign quo   = (dsgn && (rs_data[31] ^ rt_data[31])) ? (~q_u + 32'd1) : q_u;
    assign rem   = (dsgn && rs_data[31]) ? (~r_u + 32'd1) : r_u;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        3'd1: begin
                            {phi_d, plo_d} = prod_s;
                            dz_d    = 1'b0;
                            cnt_d   = 4'(MULT_LAT - 1);
                            state_d = MUL;
                        end
                        3'd2: begin
                            {phi_d, plo_d} = prod_u;
                            dz_d    = 1'b0;
                            cnt_d   = 4'(MULT_LAT - 1);
                            state_d = MUL;
                        end
                        3'd3, 3'd4: begin
                            phi_d   = rem;
                            plo_d   = quo;
                            dz_d    = (rt_data == 32'd0);
                            cnt_d   = 4'(DIV_LAT - 1);
                            state_d = DIV;
                        end
                        3'd5: hi_d = rs_data;
                        3'd6: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    if (!dz_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q != IDLE);
    // Stall also covers the start cycle, before busy has risen.
    assign md_stall = md_use_D & (busy | (start & (op_mul | op_div)));
    assign md_out   = rd_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_md_scheduler.sv
// tb_md_scheduler: directed and random checks of md_scheduler
// against a cycle-indexed behavioural model of HI/LO and busy.
module tb_md_scheduler;

    localparam int MLAT = 5;
    localparam int DLAT = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rd_sel;
    logic        md_use_D;
    logic        busy;
    logic        md_stall;
    logic [31:0] md_out;

    md_scheduler #(
        .MULT_LAT(MLAT),
        .DIV_LAT (DLAT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .rd_sel  (rd_sel),
        .md_use_D(md_use_D),
        .busy    (busy),
        .md_stall(md_stall),
        .md_out  (md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: HI/LO, pending result, and the edge index of the commit.
    logic [31:0] mhi, mlo, phi, plo;
    logic        pdz;
    longint      edge_n;
    longint      commit_e;

    logic        obs_busy;
    logic        obs_stall;
    logic [31:0] obs_out;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_edge(input logic st, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic rn, input logic mb);
        longint sa, sb;
        logic [63:0] p;
        if (!rn) begin
            mhi = 0; mlo = 0; commit_e = -1;
        end else if (mb) begin
            if (edge_n == commit_e && !pdz) begin
                mhi = phi; mlo = plo;
            end
        end else if (st) begin
            sa = longint'({{32{a[31]}}, a});
            sb = longint'({{32{b[31]}}, b});
            case (op)
                3'd1: begin
                    p = 64'(sa * sb);
                    {phi, plo} = p; pdz = 0; commit_e = edge_n + MLAT;
                end
                3'd2: begin
                    p = {32'd0, a} * {32'd0, b};
                    {phi, plo} = p; pdz = 0; commit_e = edge_n + MLAT;
                end
                3'd3: begin
                    pdz = (b == 0);
                    if (!pdz) begin
                        p = 64'(sa / sb); plo = p[31:0];
                        p = 64'(sa % sb); phi = p[31:0];
                    end
                    commit_e = edge_n + DLAT;
                end
                3'd4: begin
                    pdz = (b == 0);
                    if (!pdz) begin
                        plo = a / b; phi = a % b;
                    end
                    commit_e = edge_n + DLAT;
                end
                3'd5: mhi = a;
                3'd6: mlo = a;
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic sel, input logic ud, input logic rn);
        logic mb, ms;
        logic [31:0] mo;
        @(negedge clk);
        start = st; md_op = op; rs_data = a; rt_data = b;
        rd_sel = sel; md_use_D = ud; reset = rn;
        #1;
        mb = (edge_n <= commit_e);
        ms = ud & (mb | (st && op >= 3'd1 && op <= 3'd4));
        mo = sel ? mlo : mhi;
        obs_busy = busy; obs_stall = md_stall; obs_out = md_out;
        chk("busy", {31'd0, busy}, {31'd0, mb});
        chk("md_stall", {31'd0, md_stall}, {31'd0, ms});
        chk("md_out", md_out, mo);
        @(posedge clk);
        model_edge(st, op, a, b, rn, mb);
        edge_n++;
    endtask

    task automatic wait_idle(input logic sel, input logic ud, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 3'd0, 32'd0, 32'd0, sel, ud, 1'b1);
            if (!obs_busy) break;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] ehi,
                          input logic [31:0] elo);
        int n;
        step(1'b1, op, a, b, 1'b0, 1'b0, 1'b1);
        wait_idle(1'b0, 1'b0, n);
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk({tag, "_hi"}, obs_out, ehi);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        chk({tag, "_lo"}, obs_out, elo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] a, b;
        logic [2:0]  op;
        mhi = 0; mlo = 0; phi = 0; plo = 0; pdz = 0;
        edge_n = 0; commit_e = -1;
        reset = 0; start = 0; md_op = 0; rs_data = 0; rt_data = 0;
        rd_sel = 0; md_use_D = 0;
        repeat (2) @(posedge clk);

        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0);
        chk("rst_stall", {31'd0, obs_stall}, 32'd1);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_busy", {31'd0, obs_busy}, 32'd0);
        chk("rst_out", obs_out, 32'd0);

        run_op("mult", 3'd1, 32'hFFFFFFFD, 32'd5, MLAT,
               32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, MLAT,
               32'h00000001, 32'hFFFFFFFE);
        run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, DLAT,
               32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", 3'd4, 32'd7, 32'd2, DLAT, 32'd1, 32'd3);

        step(1'b1, 3'd5, 32'h11, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd6, 32'h22, 32'd0, 1'b0, 1'b0, 1'b1);
        run_op("div0", 3'd3, 32'd123, 32'd0, DLAT, 32'h11, 32'h22);

        // Stall held through a MULT, with a DIV start issued mid-flight.
        step(1'b1, 3'd1, 32'd7, 32'd6, 1'b0, 1'b1, 1'b1);
        chk("stall_start", {31'd0, obs_stall}, 32'd1);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 3'd3, 32'd100, 32'd7, 1'b0, 1'b1, 1'b1);
        chk("stall_mid", {31'd0, obs_stall}, 32'd1);
        wait_idle(1'b0, 1'b1, n);
        chk("ign_lat", 32'(n), 32'(MLAT - 2));
        chk("stall_end", {31'd0, obs_stall}, 32'd0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("ign_hi", obs_out, 32'd0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        chk("ign_lo", obs_out, 32'd42);

        // Reset in busy cycle 4 of a DIV.
        step(1'b1, 3'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("rstmid_busy4", {31'd0, obs_busy}, 32'd1);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        chk("rstmid_busy", {31'd0, obs_busy}, 32'd0);
        chk("rstmid_lo", obs_out, 32'd0);
        repeat (12) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("rstmid_late_hi", obs_out, 32'd0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        chk("rstmid_late_lo", obs_out, 32'd0);

        step(1'b1, 3'd5, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("mthi", obs_out, 32'hDEADBEEF);
        step(1'b1, 3'd6, 32'h1234, 32'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        chk("mtlo", obs_out, 32'h1234);

        for (int i = 0; i < 600; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            step(($urandom_range(0, 2) == 0), op, a, b,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 79) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
